// File: rtl/multicycle_data_path.sv
// Multicycle ARM-style datapath: register file, extender, ALU, instruction register and phase FSM
// on a shared req/ack memory port. Optional macro BUS_TIMEOUT_EN adds an ack timeout with a FAULT state.
module multicycle_data_path #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       RegSrc,
  input  logic             RegWrite,
  input  logic [1:0]       ImmSrc,
  input  logic             ALUSrc,
  input  logic [3:0]       ALUControl,
  input  logic             MemtoReg,
  input  logic             MemWrite,
  input  logic             MemOp,
  input  logic             PCSrc,
  input  logic             cond_ok,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [31:0]      instr,
  output logic [3:0]       ALUFlags,
  output logic [WIDTH-1:0] PC_out,
  output logic [2:0]       state,
  output logic             fault
);
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_FAULT = 3'd5
  } state_t;

  if (WIDTH < 32 || TIMEOUT < 1) begin : g_bad_param
    $error("multicycle_data_path: WIDTH must be >= 32 and TIMEOUT >= 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, a_q, b_q, imm_q, aluout_q, data_q;
  logic [31:0]      instr_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] regs_q [16];

  logic [3:0]       ra1, ra2, rd;
  logic [WIDTH-1:0] r15_val, rd1, rd2, ext_imm, src_b, alu_res, result;
  logic [WIDTH:0]   sum;
  logic             alu_c, alu_v, timeout_hit;

  // pc_q already holds fetch address + 4, so R15 reads as fetch address + 8
  assign r15_val = pc_q + WIDTH'(4);
  assign ra1     = RegSrc[0] ? 4'd15 : instr_q[19:16];
  assign ra2     = RegSrc[1] ? instr_q[15:12] : instr_q[3:0];
  assign rd      = instr_q[15:12];
  assign rd1     = (ra1 == 4'd15) ? r15_val : regs_q[ra1];
  assign rd2     = (ra2 == 4'd15) ? r15_val : regs_q[ra2];
  assign src_b   = ALUSrc ? imm_q : b_q;
  assign result  = MemtoReg ? data_q : aluout_q;

  always_comb begin
    case (ImmSrc)
      2'b00:   ext_imm = {{(WIDTH-8){1'b0}}, instr_q[7:0]};
      2'b01:   ext_imm = {{(WIDTH-12){1'b0}}, instr_q[11:0]};
      2'b10:   ext_imm = {{(WIDTH-26){instr_q[23]}}, instr_q[23:0], 2'b00};
      default: ext_imm = '0;
    endcase
  end

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      4'b0000: begin
        sum     = {1'b0, a_q} + {1'b0, src_b};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'b0001: begin
        sum     = {1'b0, a_q} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      4'b0010: alu_res = a_q & src_b;
      4'b0011: alu_res = a_q | src_b;
      4'b0100: alu_res = a_q ^ src_b;
      4'b0101: alu_res = src_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ack) state_d = S_DECODE; else state_d = S_FETCH;
      S_DECODE:  if (cond_ok) state_d = S_EXECUTE; else state_d = S_FETCH;
      S_EXECUTE: if (MemOp) state_d = S_MEM; else state_d = S_WB;
      S_MEM: begin
        if (mem_ack) state_d = MemWrite ? S_FETCH : S_WB;
        else         state_d = S_MEM;
      end
      S_WB:      state_d = S_FETCH;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_FETCH;
    endcase
    if (timeout_hit) state_d = S_FAULT;
    else             state_d = state_d;
  end

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic          waiting;
  logic [TW-1:0] tcnt_q, tcnt_d;

  assign waiting     = mem_req && !mem_ack;
  assign timeout_hit = waiting && (tcnt_q == TW'(TIMEOUT - 1));
  assign tcnt_d      = (waiting && (state_d == state_q)) ? tcnt_q + TW'(1) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tcnt_q <= '0;
    else        tcnt_q <= tcnt_d;
  end

  assign fault = (state_q == S_FAULT);
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      flags_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      imm_q    <= '0;
      aluout_q <= '0;
      data_q   <= '0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: begin
          if (mem_ack) begin
            instr_q <= mem_rdata[31:0];
            pc_q    <= pc_q + WIDTH'(4);
          end
        end
        S_DECODE: begin
          a_q   <= rd1;
          b_q   <= rd2;
          imm_q <= ext_imm;
        end
        S_EXECUTE: begin
          aluout_q <= alu_res;
          flags_q  <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
        end
        S_MEM: begin
          if (mem_ack) data_q <= mem_rdata;
        end
        S_WB: begin
          // a branch wins over a register write that targets R15
          if (PCSrc)                           pc_q       <= result;
          else if (RegWrite && rd != 4'd15)    regs_q[rd] <= result;
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = reset && (state_q == S_FETCH || state_q == S_MEM);
  assign mem_we    = reset && (state_q == S_MEM) && MemWrite;
  assign mem_addr  = (state_q == S_MEM) ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign instr     = instr_q;
  assign ALUFlags  = flags_q;
  assign PC_out    = pc_q;
  assign state     = state_q;
endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench for multicycle_data_path: ISA-level model, latency-configurable memory, per-access compare.
module tb_multicycle_data_path;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  RegSrc, ImmSrc;
  logic        RegWrite, ALUSrc, MemtoReg, MemWrite, MemOp, PCSrc, cond_ok, mem_ack;
  logic [3:0]  ALUControl, ALUFlags;
  logic [31:0] mem_rdata, mem_addr, mem_wdata, instr, PC_out;
  logic        mem_req, mem_we, fault;
  logic [2:0]  state;

  always #5 clk = ~clk;

  multicycle_data_path #(.WIDTH(32), .RESET_PC(RPC), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc),
    .ALUSrc(ALUSrc), .ALUControl(ALUControl), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .MemOp(MemOp), .PCSrc(PCSrc), .cond_ok(cond_ok), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .instr(instr), .ALUFlags(ALUFlags), .PC_out(PC_out), .state(state), .fault(fault)
  );

  typedef struct packed {
    logic [1:0] rs; logic rw; logic [1:0] is; logic as; logic [3:0] ac;
    logic m2r; logic mw; logic mop; logic pcs; logic cok;
  } ctl_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mem [1024];
  acc_t        expq [$];
  int          lat = 0;
  bit          no_ack = 1'b0;
  bit          exp_fault = 1'b0;

  logic [31:0] mr [16];
  logic [31:0] mpc;
  logic [3:0]  mflags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory responder plus compare process: acks after `lat` wait cycles and checks every access.
  int          wcnt = 0;
  bit          prev_wait = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;
  acc_t        e;
  always @(negedge clk) begin
    if (!reset) begin
      mem_ack   = 1'b0;
      wcnt      = 0;
      prev_wait = 1'b0;
    end else begin
      check("fault level", {31'd0, fault}, {31'd0, exp_fault});
      if (state == 3'd1 || state == 3'd2 || state == 3'd4 || state == 3'd5)
        check("req idle phase", {31'd0, mem_req}, 32'd0);
      if (prev_wait && mem_req) begin
        check("hold addr", mem_addr, prev_addr);
        check("hold we", {31'd0, mem_we}, {31'd0, prev_we});
        if (mem_we) check("hold wdata", mem_wdata, prev_wdata);
      end
      if (mem_ack) wcnt = 0;
      mem_ack = 1'b0;
      if (mem_req && !no_ack) begin
        if (wcnt >= lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr[11:2]];
          if (expq.size() == 0) begin
            check("unexpected access", mem_addr, 32'hDEAD_BEEF);
          end else begin
            e = expq.pop_front();
            check("access we", {31'd0, mem_we}, {31'd0, e.we});
            check("access addr", mem_addr, e.addr);
            if (e.we) check("access wdata", mem_wdata, e.wdata);
          end
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
        end else begin
          wcnt++;
        end
      end
      prev_wait  = mem_req && !mem_ack;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end
  end

  function automatic logic [31:0] rreg(input logic [3:0] idx, input logic [31:0] r15);
    return (idx == 4'd15) ? r15 : mr[idx];
  endfunction

  // Executes one instruction on the model, then runs the DUT until it returns to FETCH.
  task automatic run(input string nm, input logic [31:0] iw, input ctl_t c, input int latency, input int ncyc);
    logic [31:0] r15, a, b, imm, srcb, res, data, result, faddr;
    logic [3:0]  rd;
    logic        cf, vf;
    longint      sr;
    acc_t        x;
    int          cyc;
    bit          left;
    mem[mpc[11:2]] = iw;
    lat = latency;
    RegSrc = c.rs; RegWrite = c.rw; ImmSrc = c.is; ALUSrc = c.as; ALUControl = c.ac;
    MemtoReg = c.m2r; MemWrite = c.mw; MemOp = c.mop; PCSrc = c.pcs; cond_ok = c.cok;
    faddr = mpc;
    x.we = 1'b0; x.addr = mpc; x.wdata = 32'd0;
    expq.push_back(x);
    r15 = mpc + 32'd8;
    mpc = mpc + 32'd4;
    if (c.cok) begin
      rd = iw[15:12];
      a  = c.rs[0] ? r15 : rreg(iw[19:16], r15);
      b  = c.rs[1] ? rreg(iw[15:12], r15) : rreg(iw[3:0], r15);
      case (c.is)
        2'b00:   imm = 32'(iw[7:0]);
        2'b01:   imm = 32'(iw[11:0]);
        2'b10:   imm = 32'(int'($signed(iw[23:0])) * 4);
        default: imm = 32'd0;
      endcase
      srcb = c.as ? imm : b;
      cf = 1'b0; vf = 1'b0;
      case (c.ac)
        4'd0: begin
          res = a + srcb;
          cf  = (64'(a) + 64'(srcb)) > 64'hFFFF_FFFF;
          sr  = longint'($signed(a)) + longint'($signed(srcb));
          vf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end
        4'd1: begin
          res = a - srcb;
          cf  = (a >= srcb);
          sr  = longint'($signed(a)) - longint'($signed(srcb));
          vf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        end
        4'd2:    res = a & srcb;
        4'd3:    res = a | srcb;
        4'd4:    res = a ^ srcb;
        4'd5:    res = srcb;
        default: res = 32'd0;
      endcase
      mflags = {res[31], (res == 32'd0), cf, vf};
      data = 32'd0;
      if (c.mop) begin
        x.we = c.mw; x.addr = res; x.wdata = b;
        expq.push_back(x);
        if (!c.mw) data = mem[res[11:2]];
      end
      if (!(c.mop && c.mw)) begin
        result = c.m2r ? data : res;
        if (c.pcs)                       mpc    = result;
        else if (c.rw && rd != 4'd15)    mr[rd] = result;
      end
    end
    cyc = 0;
    left = 1'b0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (state != 3'd0) begin
        if (!left) check({nm, " pc after fetch"}, PC_out, faddr + 32'd4);
        left = 1'b1;
      end else if (left) begin
        break;
      end
    end
    if (!left || state != 3'd0) check({nm, " completion timeout"}, 32'(cyc), 32'd0);
    check({nm, " cycles"}, 32'(cyc), 32'(ncyc));
    check({nm, " pc"}, PC_out, mpc);
    check({nm, " flags"}, {28'd0, ALUFlags}, {28'd0, mflags});
    check({nm, " accesses left"}, 32'(expq.size()), 32'd0);
    for (int i = 0; i < 15; i++) check({nm, " reg"}, dut.regs_q[i], mr[i]);
  endtask

  task automatic model_reset();
    expq.delete();
    mpc = RPC;
    mflags = 4'd0;
    for (int i = 0; i < 16; i++) mr[i] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    RegSrc = 2'd0; RegWrite = 1'b0; ImmSrc = 2'd0; ALUSrc = 1'b0; ALUControl = 4'd0;
    MemtoReg = 1'b0; MemWrite = 1'b0; MemOp = 1'b0; PCSrc = 1'b0; cond_ok = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[4] = 32'h7FFF_FFFF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst state", {29'd0, state}, 32'd0);
    check("rst pc", PC_out, 32'h0000_0100);
    check("rst instr", instr, 32'd0);
    check("rst flags", {28'd0, ALUFlags}, 32'd0);
    check("rst fault", {31'd0, fault}, 32'd0);
    check("rst req", {31'd0, mem_req}, 32'd0);
    check("rst we", {31'd0, mem_we}, 32'd0);
    for (int i = 0; i < 16; i++) check("rst reg", dut.regs_q[i], 32'd0);
    reset = 1'b1;
    #1;
    check("first fetch req", {31'd0, mem_req}, 32'd1);
    check("first fetch addr", mem_addr, 32'h0000_0100);

    run("ADD", 32'hE280_1005, '{2'b00,1'b1,2'b00,1'b1,4'h0,1'b0,1'b0,1'b0,1'b0,1'b1}, 0, 4);
    check("ADD r1 literal", dut.regs_q[1], 32'd5);
    check("ADD flags literal", {28'd0, ALUFlags}, 32'h0);
    check("ADD pc literal", PC_out, 32'h0000_0104);
    run("SUBS", 32'hE051_2001, '{2'b00,1'b1,2'b00,1'b0,4'h1,1'b0,1'b0,1'b0,1'b0,1'b1}, 0, 4);
    check("SUBS flags literal", {28'd0, ALUFlags}, 32'h6);
    run("STR", 32'hE580_1008, '{2'b10,1'b0,2'b01,1'b1,4'h0,1'b0,1'b1,1'b1,1'b0,1'b1}, 3, 10);
    check("STR mem literal", mem[2], 32'd5);
    run("LDR", 32'hE590_3008, '{2'b00,1'b1,2'b01,1'b1,4'h0,1'b1,1'b0,1'b1,1'b0,1'b1}, 3, 11);
    check("LDR r3 literal", dut.regs_q[3], 32'd5);
    run("LDR0", 32'hE590_6010, '{2'b00,1'b1,2'b01,1'b1,4'h0,1'b1,1'b0,1'b1,1'b0,1'b1}, 0, 5);
    run("ADDS ovf", 32'hE096_7006, '{2'b00,1'b1,2'b00,1'b0,4'h0,1'b0,1'b0,1'b0,1'b0,1'b1}, 0, 4);
    check("ADDS ovf flags literal", {28'd0, ALUFlags}, 32'h9);
    check("ADDS ovf r7 literal", dut.regs_q[7], 32'hFFFF_FFFE);
    run("SUBS neg", 32'hE050_8001, '{2'b00,1'b1,2'b00,1'b0,4'h1,1'b0,1'b0,1'b0,1'b0,1'b1}, 0, 4);
    check("SUBS neg flags literal", {28'd0, ALUFlags}, 32'h8);
    run("ORR", 32'hE381_A0F0, '{2'b00,1'b1,2'b00,1'b1,4'h3,1'b0,1'b0,1'b0,1'b0,1'b1}, 1, 5);
    check("ORR r10 literal", dut.regs_q[10], 32'h0000_00F5);
    run("EOR", 32'hE021_B003, '{2'b00,1'b1,2'b00,1'b0,4'h4,1'b0,1'b0,1'b0,1'b0,1'b1}, 0, 4);
    run("AND", 32'hE007_C006, '{2'b00,1'b1,2'b00,1'b0,4'h2,1'b0,1'b0,1'b0,1'b0,1'b1}, 0, 4);
    run("UNK", 32'hE281_9077, '{2'b00,1'b1,2'b11,1'b1,4'h6,1'b0,1'b0,1'b0,1'b0,1'b1}, 0, 4);
    check("UNK flags literal", {28'd0, ALUFlags}, 32'h4);
    run("MOV PC", 32'hE3A0_F200, '{2'b00,1'b1,2'b01,1'b1,4'h5,1'b0,1'b0,1'b0,1'b1,1'b1}, 0, 4);
    check("MOV PC literal", PC_out, 32'h0000_0200);
    run("B", 32'hEAFF_FFFE, '{2'b01,1'b0,2'b10,1'b1,4'h0,1'b0,1'b0,1'b0,1'b1,1'b1}, 0, 4);
    check("B target literal", PC_out, 32'h0000_0200);
    run("B skip", 32'hEAFF_FFFE, '{2'b01,1'b0,2'b10,1'b1,4'h0,1'b0,1'b0,1'b0,1'b1,1'b0}, 0, 2);
    check("B skip pc literal", PC_out, 32'h0000_0204);
    run("R15 wr", 32'hE280_F001, '{2'b00,1'b1,2'b00,1'b1,4'h0,1'b0,1'b0,1'b0,1'b0,1'b1}, 0, 4);
    check("R15 wr pc literal", PC_out, 32'h0000_0208);

    // Ack never arrives: timeout build faults after 16 waits, default build keeps waiting.
    no_ack = 1'b1;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
`ifdef BUS_TIMEOUT_EN
    repeat (15) @(posedge clk);
    #1;
    check("pre-timeout state", {29'd0, state}, 32'd0);
    exp_fault = 1'b1;
    @(posedge clk); #1;
    check("timeout state", {29'd0, state}, 32'd5);
    check("timeout fault", {31'd0, fault}, 32'd1);
    check("timeout req", {31'd0, mem_req}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("fault sticky", {29'd0, state}, 32'd5);
`else
    repeat (40) @(posedge clk);
    #1;
    check("wait forever state", {29'd0, state}, 32'd0);
    check("wait forever req", {31'd0, mem_req}, 32'd1);
    check("wait forever addr", mem_addr, 32'h0000_0100);
`endif
    @(negedge clk);
    #2;
    reset = 1'b0;
    exp_fault = 1'b0;
    #1;
    check("async rst state", {29'd0, state}, 32'd0);
    check("async rst fault", {31'd0, fault}, 32'd0);
    check("async rst req", {31'd0, mem_req}, 32'd0);
    check("async rst pc", PC_out, 32'h0000_0100);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_data_path.md
Name: multicycle_data_path

Overview:
- Parametrised multicycle successor to the single-cycle ARM datapath.
- Contains the register file, extender, ALU, an instruction register and a phase sequencer (FSM).
- Talks to one shared instruction/data memory over a req/ack handshake with variable latency.
- An external combinational decoder reads `instr` and drives the control inputs. This block sequences fetch/decode/execute/memory/writeback.

Parameters:
- WIDTH, 32: data/address width, ≥32. The instruction is `mem_rdata[31:0]`.
- RESET_PC, 0: PC value loaded on reset.
- TIMEOUT, 16: maximum wait cycles for `mem_ack` (used only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- RegSrc  in  2  [0]: RA1 = 15; [1]: RA2 = Instr[15:12]
- RegWrite  in  1  write Rd in WB
- ImmSrc  in  2  extender mode
- ALUSrc  in  1  SrcB = ExtImm
- ALUControl  in  4  ALU operation
- MemtoReg  in  1  Result = memory data
- MemWrite  in  1  store in MEM
- MemOp  in  1  instruction uses MEM phase
- PCSrc  in  1  PC loaded from Result in WB
- cond_ok  in  1  condition passed
- mem_rdata  in  WIDTH  memory read data
- mem_ack  in  1  memory completes the access this cycle
- mem_req  out  1  access request
- mem_we  out  1  write strobe
- mem_addr  out  WIDTH  access address
- mem_wdata  out  WIDTH  store data
- instr  out  32  instruction register
- ALUFlags  out  4  N,Z,C,V from the last EXECUTE
- PC_out  out  WIDTH  current PC
- state  out  3  FSM state
- fault  out  1  bus timeout (see Optional Feature)

Behaviour:
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, FAULT=5.
- Reset (`reset`=0, asynchronous):
  - state=FETCH, PC=RESET_PC, instr=0, ALUFlags=0, fault=0.
  - mem_req=0, mem_we=0; all 16 registers cleared to 0.
  - Any in-flight access is abandoned immediately.
- First FETCH after reset deassertion: mem_req=1 from the first cycle.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Hold until mem_ack=1. On that edge: instr←mem_rdata[31:0], PC←PC+4, go to DECODE.
  - An ack arriving in the same cycle as the request is legal, giving 1-cycle fetch.
- DECODE:
  - A←R[RA1], B←R[RA2], Imm←Ext(instr).
  - Reading R15 returns the current PC, which is old PC+8.
  - cond_ok=0: go to FETCH (no side effects). Otherwise go to EXECUTE.
- EXECUTE:
  - ALUOut←ALU(A, SrcB); ALUFlags updated.
  - Go to MEM if MemOp=1, else WB.
- ALU, WIDTH-bit:
  - 0000 ADD, 0001 SUB (A−B), 0010 AND, 0011 ORR, 0100 EOR, 0101 MOV (B); other codes give 0.
  - N=msb, Z=(result==0).
  - C: carry-out for ADD; no-borrow for SUB; 0 for the others.
  - V: signed overflow for ADD/SUB; 0 for the others.
- Extender:
  - ImmSrc 00: zero-extend Instr[7:0].
  - ImmSrc 01: zero-extend Instr[11:0].
  - ImmSrc 10: sign-extend Instr[23:0]<<2.
  - ImmSrc 11: 0.
- MEM:
  - mem_req=1, mem_addr=ALUOut, mem_we=MemWrite, mem_wdata=B.
  - On mem_ack: Data←mem_rdata, go to WB (loads) or FETCH (stores).
  - mem_addr and mem_wdata stay stable while req=1 and ack=0.
- WB:
  - Result = MemtoReg ? Data : ALUOut.
  - RegWrite=1 with Rd≠15: R[Rd]←Result.
  - PCSrc=1: PC←Result, which takes priority over the Rd=15 write (that write is ignored).
  - Go to FETCH.
- mem_req is 0 in DECODE, EXECUTE, WB and FAULT.
- Control inputs are read only in their phase. The external decoder derives them from `instr`, so they are stable during DECODE through WB.
- PC arithmetic wraps modulo 2^WIDTH.
- CPI: 4 cycles for ALU ops with zero-wait memory; 5 for loads; 4 for stores.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter runs while mem_req=1 and mem_ack=0.
  - If it reaches TIMEOUT, go to FAULT. In FAULT, fault=1 and mem_req=0, and the block stays there until reset.
  - The counter clears on every ack and on every state change.
- Not defined:
  - The block waits for ack indefinitely.
  - fault is tied to 0 and FAULT is unreachable.

Test Plan:
- Reset with RESET_PC=0x100 and zero-wait memory → mem_addr=0x100 in the first FETCH cycle; PC_out=0x104 after the first ack.
- ADD R1,R0,#5 (ImmSrc=00, ALUSrc=1, ALUControl=0000, RegWrite=1) after reset → R1=5 after 4 cycles; ALUFlags=0000.
- SUBS R2,R1,R1 with R1=5 → Result=0; ALUFlags N=0, Z=1, C=1, V=0.
- STR R1,[R0,#8], then LDR R3,[R0,#8], with memory ack delayed 3 cycles → write of 5 to address 8 (mem_we=1, address/data stable while waiting); R3=5; the load takes 5+6 wait cycles.
- B with imm24=0xFFFFFE from PC=0x200 → target = 0x208 + (−8) = 0x200; cond_ok=0 on the same instruction → PC=0x204 and registers unchanged.
- BUS_TIMEOUT_EN with TIMEOUT=16 and ack never asserted → state=FAULT and fault=1 after 16 cycles; reset pulse mid-FAULT → state=FETCH and fault=0.
